// File: rtl/prio_arbiter.sv
// prio_arbiter: three-requester arbiter with priority 2 > 1 > 0, a registered one-hot grant and a hold-time limit.
// Latency: a grant appears one edge after the request is seen in IDLE, and it is released one edge after the owner drops its request.
// Backpressure: there is none. A timed-out owner is locked out until it drops its request. Define ARB_ROUND_ROBIN_EN to rotate priority.
module prio_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       expire
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    lock_q, lock_d, lock_set;
  logic [2:0]    eligible, pick;
  logic [CW-1:0] hold_q, hold_d;
  logic          expire_q, expire_d;
  logic          owner_req, at_limit;

  assign eligible  = req & ~lock_q;
  assign owner_req = |(req & gnt_q);
  assign at_limit  = (hold_q == CW'(HOLD_MAX));

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;

  // Winner selection: the search order rotates so that the previous owner is checked last.
  always_comb begin
    pick = 3'b000;
    case (last_q)
      2'd1: begin
        if (eligible[0])      pick = 3'b001;
        else if (eligible[2]) pick = 3'b100;
        else if (eligible[1]) pick = 3'b010;
      end
      2'd2: begin
        if (eligible[1])      pick = 3'b010;
        else if (eligible[0]) pick = 3'b001;
        else if (eligible[2]) pick = 3'b100;
      end
      default: begin
        if (eligible[2])      pick = 3'b100;
        else if (eligible[1]) pick = 3'b010;
        else if (eligible[0]) pick = 3'b001;
      end
    endcase
  end

  // The last-owner pointer moves when a grant is issued. A release does not move it.
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && |eligible) begin
      if (pick[2])      last_d = 2'd2;
      else if (pick[1]) last_d = 2'd1;
      else              last_d = 2'd0;
    end
  end
`else
  // Winner selection: fixed priority, requester 2 highest.
  always_comb begin
    pick = 3'b000;
    if (eligible[2])      pick = 3'b100;
    else if (eligible[1]) pick = 3'b010;
    else if (eligible[0]) pick = 3'b001;
  end
`endif

  // State register: holds the FSM state, the grant, the hold counter, the lockout bits and the expire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 3'b000;
      hold_q   <= '0;
      lock_q   <= 3'b000;
      expire_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      lock_q   <= lock_d;
      expire_q <= expire_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  // Next state: issue a grant, extend it, release it, or revoke it on timeout.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    expire_d = 1'b0;
    lock_set = 3'b000;
    case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        if (|eligible) begin
          state_d = GRANT;
          gnt_d   = pick;
          hold_d  = CW'(1);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          hold_d  = '0;
        end else if (!at_limit) begin
          hold_d = hold_q + CW'(1);
        end else begin
          state_d  = IDLE;
          gnt_d    = 3'b000;
          hold_d   = '0;
          expire_d = 1'b1;
          lock_set = gnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        hold_d  = '0;
      end
    endcase
    // A low request clears its lock bit. The clear wins over a set in the same cycle.
    lock_d = (lock_q | lock_set) & req;
  end

  // Outputs: all are derived from registers, so gnt_id always tracks gnt.
  always_comb begin
    gnt    = gnt_q;
    busy   = |gnt_q;
    expire = expire_q;
    case (gnt_q)
      3'b100:  gnt_id = 2'd3;
      3'b010:  gnt_id = 2'd2;
      3'b001:  gnt_id = 2'd1;
      default: gnt_id = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Testbench for prio_arbiter with HOLD_MAX=4.
// Runs a directed vector table, a round-robin sequence when ARB_ROUND_ROBIN_EN is defined, and random traffic checked against a model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_prio_arbiter;

  localparam int HM = 4;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       expire;

  int total = 0;
  int bad   = 0;

  prio_arbiter #(.HOLD_MAX(HM)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .expire (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: owner index (-1 when there is no owner), cycles held, lockouts and the last owner.
  int       m_owner = -1;
  int       m_held  = 0;
  bit [2:0] m_lock  = 3'b000;
  bit       m_exp   = 1'b0;
  int       m_last  = 0;

  function automatic int choose(bit [2:0] e);
    int c;
    for (int j = 1; j <= 3; j++) begin
`ifdef ARB_ROUND_ROBIN_EN
      c = (m_last + 3 - j) % 3;
`else
      c = 3 - j;
`endif
      if (e[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input bit [2:0] r, input bit s);
    bit [2:0] nl;
    int       w;
    if (s) begin
      m_owner = -1; m_held = 0; m_lock = 3'b000; m_exp = 1'b0; m_last = 0;
      return;
    end
    nl    = m_lock;
    m_exp = 1'b0;
    if (m_owner < 0) begin
      w = choose(r & ~m_lock);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_last = w;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (m_held < HM) begin
      m_held++;
    end else begin
      nl[m_owner] = 1'b1;
      m_exp       = 1'b1;
      m_owner     = -1;
    end
    m_lock = nl & r;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, and return after the outputs have settled.
  task automatic cycle(input bit [2:0] r, input bit s);
    req = r;
    rst = s;
    @(posedge clk);
    model_step(r, s);
    #1;
  endtask

  task automatic chk_model(input string tag);
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk({tag, " gnt"},    int'(gnt),    eg);
    chk({tag, " gnt_id"}, int'(gnt_id), m_owner + 1);
    chk({tag, " busy"},   int'(busy),   (eg != 0) ? 1 : 0);
    chk({tag, " expire"}, int'(expire), int'(m_exp));
  endtask

  typedef struct {
    bit       rst;
    bit [2:0] req;
    bit [2:0] gnt;
    bit [1:0] id;
    bit       exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit s, input bit [2:0] r, input bit [2:0] g, input bit [1:0] i, input bit e);
    vec_t v;
    v.rst = s; v.req = r; v.gnt = g; v.id = i; v.exp = e;
    tv.push_back(v);
  endtask

  initial begin
    bit [2:0] rr;
    bit       rs;
    req = 3'b111;
    rst = 1'b1;

    // Reset behaviour and fixed-priority handover.
    add(1, 3'b111, 3'b000, 0, 0);
    add(1, 3'b111, 3'b000, 0, 0);
    add(0, 3'b111, 3'b100, 3, 0);
    add(0, 3'b011, 3'b000, 0, 0);
    add(0, 3'b011, 3'b010, 2, 0);
    add(0, 3'b011, 3'b010, 2, 0);
    add(0, 3'b011, 3'b010, 2, 0);
    add(0, 3'b001, 3'b000, 0, 0);
    // Timeout of requester 0, lockout, then a regrant after the request toggles.
    add(0, 3'b001, 3'b001, 1, 0);
    add(0, 3'b001, 3'b001, 1, 0);
    add(0, 3'b001, 3'b001, 1, 0);
    add(0, 3'b001, 3'b001, 1, 0);
    add(0, 3'b001, 3'b000, 0, 1);
    add(0, 3'b001, 3'b000, 0, 0);
    add(0, 3'b001, 3'b000, 0, 0);
    add(0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b001, 3'b001, 1, 0);
    add(0, 3'b000, 3'b000, 0, 0);
    // Requester 2 times out, requester 0 takes over, and requester 2 is locked until it toggles.
    add(0, 3'b101, 3'b100, 3, 0);
    add(0, 3'b101, 3'b100, 3, 0);
    add(0, 3'b101, 3'b100, 3, 0);
    add(0, 3'b101, 3'b100, 3, 0);
    add(0, 3'b101, 3'b000, 0, 1);
    add(0, 3'b101, 3'b001, 1, 0);
    add(0, 3'b101, 3'b001, 1, 0);
    add(0, 3'b001, 3'b001, 1, 0);
    add(0, 3'b101, 3'b001, 1, 0);
    add(0, 3'b101, 3'b000, 0, 1);
    add(0, 3'b101, 3'b100, 3, 0);
    // The owner drops its request on the limit cycle: this is a release with no expire and no lock.
    add(0, 3'b101, 3'b100, 3, 0);
    add(0, 3'b101, 3'b100, 3, 0);
    add(0, 3'b101, 3'b100, 3, 0);
    add(0, 3'b001, 3'b000, 0, 0);
    add(0, 3'b100, 3'b100, 3, 0);
    add(0, 3'b100, 3'b100, 3, 0);
    add(0, 3'b100, 3'b100, 3, 0);
    // Reset in the middle of a grant.
    add(1, 3'b100, 3'b000, 0, 0);
    add(0, 3'b100, 3'b100, 3, 0);
    add(0, 3'b000, 3'b000, 0, 0);

    foreach (tv[n]) begin
      cycle(tv[n].req, tv[n].rst);
      chk($sformatf("vec%0d gnt", n),    int'(gnt),    int'(tv[n].gnt));
      chk($sformatf("vec%0d gnt_id", n), int'(gnt_id), int'(tv[n].id));
      chk($sformatf("vec%0d busy", n),   int'(busy),   (tv[n].gnt != 0) ? 1 : 0);
      chk($sformatf("vec%0d expire", n), int'(expire), int'(tv[n].exp));
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin: each owner drops for one cycle, giving the grant order 2, 1, 0, 2, 1.
    cycle(3'b111, 1'b1);
    cycle(3'b111, 1'b0);
    chk("rr first", int'(gnt), 4);
    cycle(3'b011, 1'b0);
    cycle(3'b111, 1'b0);
    chk("rr second", int'(gnt), 2);
    cycle(3'b101, 1'b0);
    cycle(3'b111, 1'b0);
    chk("rr third", int'(gnt), 1);
    cycle(3'b110, 1'b0);
    cycle(3'b111, 1'b0);
    chk("rr fourth", int'(gnt), 4);
    cycle(3'b011, 1'b0);
    cycle(3'b111, 1'b0);
    chk("rr fifth", int'(gnt), 2);
`endif

    // Random traffic compared against the model. Requests change occasionally so that timeouts occur.
    rr = 3'b000;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) rr = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 79) == 0);
      cycle(rr, rs);
      chk_model($sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
